mult_div_unit: RTL

//   Iterative multiply/divide unit producing HI/LO results for MULT, MULTU, DIV and DIVU.

---
 rtl/mult_div_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU with HI/LO results.
// Radix-2 shift-add multiply and restoring divide over magnitudes, sign fix in one extra cycle.
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic           is_div, sign_a, sign_b, dbz;
    logic [N-1:0]   orig_a;
    logic [N-1:0]   opnd;
    logic [N-1:0]   acc_hi;
    logic [N-1:0]   acc_lo;

    logic           accept;
    logic           op_signed, op_div;
    logic [N-1:0]   mag_a, mag_b;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N:0]     div_diff;
    logic [2*N-1:0] prod;
    logic [N-1:0]   fix_hi, fix_lo;

    assign accept    = start && (state == IDLE || state == DONE);
    assign op_signed = ~op[0];
    assign op_div    = op[1];
    assign mag_a     = (op_signed && inA[N-1]) ? -inA : inA;
    assign mag_b     = (op_signed && inB[N-1]) ? -inB : inB;

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    // Multiply: acc_hi holds the running upper half, acc_lo shifts the multiplier out.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi, acc_lo[N-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign prod      = {acc_hi, acc_lo};

    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!is_div) begin
            {fix_hi, fix_lo} = (sign_a ^ sign_b) ? -prod : prod;
        end else if (dbz) begin
            fix_hi = orig_a;
            fix_lo = '1;
        end else begin
            fix_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
            fix_hi = sign_a ? -acc_hi : acc_hi;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (cnt == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dbz         <= 1'b0;
            orig_a      <= '0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= CW'(N - 1);
            is_div <= op_div;
            sign_a <= op_signed && inA[N-1];
            sign_b <= op_signed && inB[N-1];
            dbz    <= op_div && (inB == '0);
            orig_a <= inA;
            opnd   <= op_div ? mag_b : mag_a;
            acc_hi <= '0;
            acc_lo <= op_div ? mag_a : mag_b;
        end else if (state == CALC) begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
                if (!div_diff[N]) begin
                    acc_hi <= div_diff[N-1:0];
                    acc_lo <= {acc_lo[N-2:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[N-1:0];
                    acc_lo <= {acc_lo[N-2:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[N:1];
                acc_lo <= {mul_sum[0], acc_lo[N-1:1]};
            end
        end else if (state == FIX) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            div_by_zero <= is_div && dbz;
        end
    end

endmodule
